dual_param: RTL
===============

DUAL_PARAM -- requirements
Module: dual_param

Interface
REQ-001 Parameter DATA_W, default 8: word width in bits.
REQ-002 Parameter ADDR_W, default 6: address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter RD_MODE, default 0: same-port read-during-write; 0 = read-first (old data), 1 = write-first (new data).
REQ-004 Parameter INIT_VAL, default 0 (DATA_W bits): value written to every word by the clear sequence.
REQ-005 Ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en1  input  1  port 1 access enable.
- we1  input  1  port 1 write enable; qualified by en1.
- addr1  input  ADDR_W  port 1 address.
- data1  input  DATA_W  port 1 write data.
- dout1  output  DATA_W  port 1 registered read data.
- en2, we2, addr2, data2, dout2: port 2 equivalents, same directions and widths.
- busy  output  1  clear sequence in progress; port accesses ignored.
- collision  output  1  present only with DUAL_COLLISION_EN (REQ-021).

Function
REQ-006 Storage SHALL be DEPTH x DATA_W, shared by both ports, both fully read/write capable.
REQ-007 A port SHALL write data to mem[addr] at the rising edge when en=1, we=1 and busy=0.
REQ-008 A port SHALL load dout with mem[addr] at the rising edge when en=1 and busy=0; read latency is exactly 1 cycle.
REQ-009 dout SHALL hold its value when en=0, including during writes on the other port.
REQ-010 Same-port read during write: dout SHALL be the old word when RD_MODE=0 and the new word (data) when RD_MODE=1.
REQ-011 Cross-port read of an address written by the other port in the same cycle SHALL return the old word, whatever RD_MODE is.
REQ-012 Both ports writing the same address in the same cycle: port 1 data SHALL be stored and port 2 data discarded.
REQ-013 The clear FSM SHALL have states IDLE and CLEAR, with an ADDR_W-bit pointer ptr.
REQ-014 In CLEAR, mem[ptr] SHALL be set to INIT_VAL each cycle and ptr SHALL increment; at ptr = DEPTH-1 the FSM SHALL go to IDLE after that write.
REQ-015 busy SHALL be 1 exactly while the FSM is in CLEAR (DEPTH cycles) and 0 in IDLE.
REQ-016 While busy=1, all port writes SHALL be dropped and dout1/dout2 SHALL hold 0.
REQ-017 The first port access SHALL be accepted on the first edge at which busy=0.

Reset
REQ-018 When rst=1 is sampled at an edge: dout1=0, dout2=0, ptr=0, FSM=CLEAR, busy=1 (collision=0 if present).
REQ-019 rst asserted during CLEAR SHALL restart the sequence from ptr=0; a full DEPTH-cycle clear follows the last rst-high edge.
REQ-020 rst SHALL take priority over all port activity in the same cycle.

Configuration
REQ-021 Macro DUAL_COLLISION_EN defined: collision output exists; it SHALL be 1 for one cycle after any edge with busy=0, en1=en2=1, addr1=addr2 and (we1|we2)=1; otherwise 0.
REQ-022 Macro DUAL_COLLISION_EN undefined: collision port and its logic are absent; REQ-011 and REQ-012 still apply.

Verification (defaults: DATA_W=8, ADDR_W=6, INIT_VAL=0)
REQ-023 Pulse rst for 1 cycle -> busy=1 for exactly 64 cycles; then reads of addr 0, 31, 63 return 0 one cycle after request.
REQ-024 Cycle N: we1 writes 8'd1 to addr 5 and we2 writes 8'd2 to addr 6. Cycle N+1: port 1 reads 6 and port 2 reads 5 -> dout1=2, dout2=1 at N+2.
REQ-025 Both ports write addr 7 (port 1 8'd3, port 2 8'd9) -> later read of addr 7 returns 3; collision=1 for one cycle (macro defined).
REQ-026 mem[10]=8'hAA; port 1 writes 8'h55 to addr 10 while reading it -> dout1=AA (RD_MODE=0) or 55 (RD_MODE=1); port 2 reading addr 10 in the same cycle gets AA.
REQ-027 rst asserted at cycle 20 of the clear -> busy stays 1 for 64 cycles after rst deasserts; writes attempted with busy=1 leave memory at INIT_VAL.
REQ-028 en1=0 with addr1 changing -> dout1 holds its last value.

Source files
------------

// File: rtl/dual_param.sv
// Dual-port DEPTH x DATA_W RAM with a self-clearing sequence after reset; optional DUAL_COLLISION_EN adds a collision flag.
// Latency: 1 cycle from accepted request to dout; clearing takes DEPTH cycles after the last reset edge.
// Backpressure: busy=1 while clearing; port accesses are dropped, not queued, and both douts are held at 0.
module dual_param #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 6,
    parameter int                RD_MODE  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] dout1,
    input  logic              en2,
    input  logic              we2,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] data2,
    output logic [DATA_W-1:0] dout2,
    output logic              busy
`ifdef DUAL_COLLISION_EN
    ,
    output logic              collision
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit WR_FIRST = (RD_MODE != 0);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic rd1, rd2, wr1, wr2;

    assign busy = (state == CLEAR);
    assign rd1  = en1 && !busy;
    assign rd2  = en2 && !busy;
    assign wr1  = rd1 && we1;
    assign wr2  = rd2 && we2;

    // ptr wraps naturally to 0 on the final clear write
    always_ff @(posedge clk) begin : clear_fsm
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else if (state == CLEAR) begin
            ptr <= ptr + 1'b1;
            if (&ptr) begin
                state <= IDLE;
            end
        end
    end

    // Port 1 is written last so it wins a same-address write race
    always_ff @(posedge clk) begin : mem_write
        if (!rst) begin
            if (busy) begin
                mem[ptr] <= INIT_VAL;
            end else begin
                if (wr2) begin
                    mem[addr2] <= data2;
                end
                if (wr1) begin
                    mem[addr1] <= data1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin : port1_read
        if (rst || busy) begin
            dout1 <= '0;
        end else if (en1) begin
            dout1 <= (WR_FIRST && we1) ? data1 : mem[addr1];
        end
    end

    always_ff @(posedge clk) begin : port2_read
        if (rst || busy) begin
            dout2 <= '0;
        end else if (en2) begin
            dout2 <= (WR_FIRST && we2) ? data2 : mem[addr2];
        end
    end

`ifdef DUAL_COLLISION_EN
    always_ff @(posedge clk) begin : collision_flag
        if (rst) begin
            collision <= 1'b0;
        end else begin
            collision <= rd1 && rd2 && (addr1 == addr2) && (we1 || we2);
        end
    end
`endif

endmodule
